keccak_absorb_sequencer: RTL and testbench

- Streams 64-bit message lanes into the rate portion of the Keccak state.
- Each lane is XORed with the matching stored state lane through a fixed-latency DSP-style XOR pipeline.
- XORed lanes are emitted as indexed write-backs.
- Sequences whole blocks: absorb RATE_LANES lanes, drain the pipeline, hand off to the permutation, wait for it to finish, then accept the next block.

---
 rtl/keccak_absorb_sequencer_pkg.sv | 22 ++
 rtl/keccak_absorb_sequencer_lane_xor_pipe.sv | 103 ++++++++++
 rtl/keccak_absorb_sequencer.sv | 175 +++++++++++++++++
 tb/tb_keccak_absorb_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_absorb_sequencer_pkg.sv
// Shared types for the Keccak absorb sequencer: lane and index types,
// the absorb FSM state encoding and the DSP-style XOR slice helper.
package sha3_absorb_pkg;

    localparam int MAX_LANES = 25;

    typedef logic [63:0] lane_t;
    typedef logic [4:0]  lane_idx_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ABSORB    = 2'd1,
        DRAIN     = 2'd2,
        WAIT_PERM = 2'd3
    } absorb_state_t;

    // One 48-bit XOR slice, the unit that maps onto a DSP logic unit.
    function automatic logic [47:0] dsp_xor48(input logic [47:0] a, input logic [47:0] b);
        return a ^ b;
    endfunction

endpackage

// File: rtl/keccak_absorb_sequencer_lane_xor_pipe.sv
// Fixed-latency 64-bit XOR pipeline built from two 48-bit XOR slices
// (bits 47:0 and zero-extended bits 63:48). Operands pass through
// XOR_LATENCY-1 register stages, then one result register; valid and
// index travel alongside in a matched shift register.
module lane_xor_pipe
    import sha3_absorb_pkg::*;
#(
    parameter int XOR_LATENCY = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      in_valid,
    input  lane_idx_t in_index,
    input  lane_t     in_a,
    input  lane_t     in_b,
    output logic      out_valid,
    output lane_idx_t out_index,
    output lane_t     out_data,
    output logic      active
);

    logic      vld_r [XOR_LATENCY];
    lane_idx_t idx_r [XOR_LATENCY];
    lane_t     op_a_s;
    lane_t     op_b_s;
    lane_t     res_r;
    logic [47:0] lo_s;
    logic [15:0] hi_s;
    logic      active_s;

    // Valid and index sideband shift register, same depth as the data path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < XOR_LATENCY; k++) begin
                vld_r[k] <= 1'b0;
                idx_r[k] <= 5'd0;
            end
        end else begin
            vld_r[0] <= in_valid;
            idx_r[0] <= in_index;
            for (int k = 1; k < XOR_LATENCY; k++) begin
                vld_r[k] <= vld_r[k-1];
                idx_r[k] <= idx_r[k-1];
            end
        end
    end

    generate
        if (XOR_LATENCY > 1) begin : g_op_stages
            lane_t opa_r [XOR_LATENCY-1];
            lane_t opb_r [XOR_LATENCY-1];

            // Operand register stages ahead of the XOR slices.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < XOR_LATENCY-1; k++) begin
                        opa_r[k] <= 64'd0;
                        opb_r[k] <= 64'd0;
                    end
                end else begin
                    opa_r[0] <= in_a;
                    opb_r[0] <= in_b;
                    for (int k = 1; k < XOR_LATENCY-1; k++) begin
                        opa_r[k] <= opa_r[k-1];
                        opb_r[k] <= opb_r[k-1];
                    end
                end
            end

            assign op_a_s = opa_r[XOR_LATENCY-2];
            assign op_b_s = opb_r[XOR_LATENCY-2];
        end else begin : g_no_op_stages
            assign op_a_s = in_a;
            assign op_b_s = in_b;
        end
    endgenerate

    assign lo_s = dsp_xor48(op_a_s[47:0], op_b_s[47:0]);
    assign hi_s = 16'(dsp_xor48({32'd0, op_a_s[63:48]}, {32'd0, op_b_s[63:48]}));

    // Result register joining the two slices.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_r <= 64'd0;
        end else begin
            res_r <= {hi_s, lo_s};
        end
    end

    // Any lane still in flight inside the pipe.
    always_comb begin
        active_s = 1'b0;
        for (int k = 0; k < XOR_LATENCY; k++) begin
            active_s = active_s | vld_r[k];
        end
    end

    assign out_valid = vld_r[XOR_LATENCY-1];
    assign out_index = idx_r[XOR_LATENCY-1];
    assign out_data  = res_r;
    assign active    = active_s;

endmodule

// File: rtl/keccak_absorb_sequencer.sv
// Keccak absorb sequencer: accepts message lanes, reads the matching state
// lane, XORs them through a fixed-latency pipe and emits indexed
// write-backs, stepping block by block with a permutation handshake.
module keccak_absorb_sequencer
    import sha3_absorb_pkg::*;
#(
    parameter int RATE_LANES  = 17,
    parameter int XOR_LATENCY = 3,
    parameter int LANE_W      = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              msg_valid,
    input  logic [LANE_W-1:0] msg_data,
    input  logic              msg_last,
    output logic              msg_ready,
    output logic [4:0]        st_rd_addr,
    input  logic [LANE_W-1:0] st_rd_data,
    output logic              xo_valid,
    output logic [4:0]        xo_index,
    output logic [LANE_W-1:0] xo_data,
    output logic              block_done,
    input  logic              perm_done,
    output logic              all_done,
    output logic              busy,
    output logic              proto_err
);

    localparam lane_idx_t LAST_IDX = lane_idx_t'(RATE_LANES - 1);

    absorb_state_t state_r;
    absorb_state_t state_nxt_s;
    lane_idx_t     cnt_r;
    lane_idx_t     rd_addr_r;
    logic          is_final_r;
    logic          proto_err_r;
    logic          aln_valid_r;
    lane_idx_t     aln_index_r;
    lane_t         aln_data_r;

    logic          accept_s;
    logic          last_lane_s;
    logic          pipe_active_s;
    logic          drain_empty_s;
    logic          msg_ready_s;
    logic          block_done_s;
    logic          all_done_s;

    assign accept_s      = msg_valid && (state_r == ABSORB);
    assign last_lane_s   = (cnt_r == LAST_IDX);
    assign drain_empty_s = !aln_valid_r && !pipe_active_s;

    // Next-state and per-state strobes.
    always_comb begin
        state_nxt_s  = state_r;
        msg_ready_s  = 1'b0;
        block_done_s = 1'b0;
        all_done_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = ABSORB;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ABSORB: begin
                msg_ready_s = 1'b1;
                if (accept_s && last_lane_s) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = ABSORB;
                end
            end
            DRAIN: begin
                if (drain_empty_s) begin
                    if (is_final_r) begin
                        all_done_s  = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        block_done_s = 1'b1;
                        state_nxt_s  = WAIT_PERM;
                    end
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            WAIT_PERM: begin
                if (perm_done) begin
                    state_nxt_s = ABSORB;
                end else begin
                    state_nxt_s = WAIT_PERM;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Lane counter, final-block flag and held read address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= 5'd0;
            rd_addr_r  <= 5'd0;
            is_final_r <= 1'b0;
        end else if (accept_s) begin
            rd_addr_r <= cnt_r;
            if (last_lane_s) begin
                cnt_r      <= 5'd0;
                is_final_r <= msg_last;
            end else begin
                cnt_r <= cnt_r + 5'd1;
            end
        end
    end

    // Sticky protocol error: early msg_last or a stray perm_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err_r <= 1'b0;
        end else if ((accept_s && msg_last && !last_lane_s) ||
                     (perm_done && (state_r != WAIT_PERM))) begin
            proto_err_r <= 1'b1;
        end
    end

    // Alignment stage: delay the lane and its index to meet st_rd_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aln_valid_r <= 1'b0;
            aln_index_r <= 5'd0;
            aln_data_r  <= 64'd0;
        end else begin
            aln_valid_r <= accept_s;
            aln_index_r <= cnt_r;
            if (accept_s) begin
                aln_data_r <= lane_t'(msg_data);
            end
        end
    end

    lane_xor_pipe #(
        .XOR_LATENCY (XOR_LATENCY)
    ) u_xor_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (aln_valid_r),
        .in_index  (aln_index_r),
        .in_a      (aln_data_r),
        .in_b      (lane_t'(st_rd_data)),
        .out_valid (xo_valid),
        .out_index (xo_index),
        .out_data  (xo_data),
        .active    (pipe_active_s)
    );

    assign st_rd_addr = accept_s ? cnt_r : rd_addr_r;
    assign msg_ready  = msg_ready_s;
    assign block_done = block_done_s;
    assign all_done   = all_done_s;
    assign busy       = (state_r != IDLE);
    assign proto_err  = proto_err_r;

endmodule

// File: tb/tb_keccak_absorb_sequencer.sv
// Bench for keccak_absorb_sequencer: two instances (XOR_LATENCY 3 and 1)
// share stimulus; a table of lanes with expected write-backs drives each
// block and a scoreboard checks every write-back's index, data and cycle.
module tb_keccak_absorb_sequencer;
    import sha3_absorb_pkg::*;

    localparam int RL = 17;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, msg_valid, msg_last, perm_done;
    lane_t msg_data;

    logic ready_a, xv_a, bd_a, ad_a, busy_a, pe_a;
    logic [4:0] addr_a, xi_a;
    lane_t rd_a, xd_a;
    logic ready_b, xv_b, bd_b, ad_b, busy_b, pe_b;
    logic [4:0] addr_b, xi_b;
    lane_t rd_b, xd_b;

    keccak_absorb_sequencer #(.RATE_LANES(RL), .XOR_LATENCY(3), .LANE_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .msg_valid(msg_valid),
        .msg_data(msg_data), .msg_last(msg_last), .msg_ready(ready_a),
        .st_rd_addr(addr_a), .st_rd_data(rd_a), .xo_valid(xv_a),
        .xo_index(xi_a), .xo_data(xd_a), .block_done(bd_a),
        .perm_done(perm_done), .all_done(ad_a), .busy(busy_a), .proto_err(pe_a));

    keccak_absorb_sequencer #(.RATE_LANES(RL), .XOR_LATENCY(1), .LANE_W(64)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .start(start), .msg_valid(msg_valid),
        .msg_data(msg_data), .msg_last(msg_last), .msg_ready(ready_b),
        .st_rd_addr(addr_b), .st_rd_data(rd_b), .xo_valid(xv_b),
        .xo_index(xi_b), .xo_data(xd_b), .block_done(bd_b),
        .perm_done(perm_done), .all_done(ad_b), .busy(busy_b), .proto_err(pe_b));

    // State memory model: lane i holds ~i, read data one cycle after address.
    always @(posedge clk) begin
        rd_a <= ~(lane_t'(addr_a));
        rd_b <= ~(lane_t'(addr_b));
    end

    typedef struct {
        lane_t     msg;
        logic      gap;
        lane_idx_t idx;
        lane_t     exp;
    } vec_t;

    typedef struct {
        lane_idx_t idx;
        lane_t     data;
        int        due;
    } exp_t;

    vec_t tbl [RL];
    exp_t q_a [$];
    exp_t q_b [$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_xo_a = 0, n_bd_a = 0, n_ad_a = 0, last_xo_a = 0;
    int n_xo_b = 0, n_bd_b = 0, n_ad_b = 0, last_xo_b = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard / pulse monitor, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (q_a.size() > 0 && q_a[0].due == cyc) begin
                chk("xo_valid_a", xv_a, 1'b1);
                chk("xo_index_a", xi_a, q_a[0].idx);
                chk("xo_data_a", xd_a, q_a[0].data);
                void'(q_a.pop_front());
            end else if (xv_a) begin
                chk("xo_spurious_a", xv_a, 1'b0);
            end
            if (xv_a) begin
                n_xo_a++;
                last_xo_a = cyc;
            end
            if (bd_a || ad_a) chk("done_timing_a", cyc, last_xo_a + 1);
            if (bd_a) n_bd_a++;
            if (ad_a) n_ad_a++;

            if (q_b.size() > 0 && q_b[0].due == cyc) begin
                chk("xo_valid_b", xv_b, 1'b1);
                chk("xo_index_b", xi_b, q_b[0].idx);
                chk("xo_data_b", xd_b, q_b[0].data);
                void'(q_b.pop_front());
            end else if (xv_b) begin
                chk("xo_spurious_b", xv_b, 1'b0);
            end
            if (xv_b) begin
                n_xo_b++;
                last_xo_b = cyc;
            end
            if (bd_b || ad_b) chk("done_timing_b", cyc, last_xo_b + 1);
            if (bd_b) n_bd_b++;
            if (ad_b) n_ad_b++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        n_xo_a = 0; n_bd_a = 0; n_ad_a = 0;
        n_xo_b = 0; n_bd_b = 0; n_ad_b = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Offer lane i until accepted (bounded); register its expected write-backs.
    task automatic send_lane(input int i, input logic last, input logic gap);
        logic acc;
        if (gap) tick();
        msg_valid = 1'b1;
        msg_data  = tbl[i].msg;
        msg_last  = last;
        acc = 1'b0;
        for (int w = 0; w < 40 && !acc; w++) begin
            @(negedge clk);
            if (ready_a) acc = 1'b1;
            else tick();
        end
        chk("lane_accepted", acc, 1'b1);
        if (acc) begin
            chk("st_rd_addr_a", addr_a, tbl[i].idx);
            chk("st_rd_addr_b", addr_b, tbl[i].idx);
            q_a.push_back('{idx: tbl[i].idx, data: tbl[i].exp, due: cyc + 4});
            q_b.push_back('{idx: tbl[i].idx, data: tbl[i].exp, due: cyc + 2});
        end
        tick();
        msg_valid = 1'b0;
        msg_last  = 1'b0;
    endtask

    task automatic send_block(input logic final_blk, input logic bubbles, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            send_lane(i, final_blk && (i == RL - 1), bubbles && tbl[i].gap);
        end
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int w = 0; w < 200 && !ok; w++) begin
            @(negedge clk);
            ok = !busy_a && !busy_b;
        end
        chk("idle_reached", ok, 1'b1);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [16:0] gap_pat;
        logic ok;
        rst_n = 1'b0; start = 1'b0; msg_valid = 1'b0; msg_last = 1'b0;
        perm_done = 1'b0; msg_data = 64'd0;
        gap_pat = 17'b1_0110_1001_1010_0110;
        for (int i = 0; i < RL; i++) begin
            tbl[i].msg = 64'h0101_0101_0101_0101 * lane_t'(i);
            tbl[i].gap = gap_pat[i];
            tbl[i].idx = lane_idx_t'(i);
            tbl[i].exp = tbl[i].msg ^ ~(lane_t'(i));
        end

        // Reset state.
        repeat (3) tick();
        @(negedge clk);
        chk("rst_ctrl_a", {xv_a, bd_a, ad_a, busy_a, pe_a, ready_a, addr_a, xi_a}, 16'd0);
        chk("rst_xo_data_a", xd_a, 64'd0);
        chk("rst_ctrl_b", {xv_b, bd_b, ad_b, busy_b, pe_b, ready_b}, 6'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single final block, no bubbles.
        clear_counts();
        do_start();
        send_block(1'b1, 1'b0, 0, RL - 1);
        wait_idle();
        chk("t1_all_done_a", n_ad_a, 1);
        chk("t1_block_done_a", n_bd_a, 0);
        chk("t1_all_done_b", n_ad_b, 1);
        chk("t1_xo_count_a", n_xo_a, 17);
        chk("t1_xo_count_b", n_xo_b, 17);
        chk("t1_busy_a", busy_a, 1'b0);
        chk("t1_proto_err", pe_a, 1'b0);

        // Two blocks with a 10-cycle permutation.
        clear_counts();
        do_start();
        send_block(1'b0, 1'b0, 0, RL - 1);
        ok = 1'b0;
        for (int w = 0; w < 100 && !ok; w++) begin
            @(negedge clk);
            ok = bd_a;
        end
        chk("t2_block_done_seen", ok, 1'b1);
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            chk("t2_ready_in_wait", ready_a, 1'b0);
        end
        tick();
        perm_done = 1'b1;
        @(negedge clk);
        chk("t2_ready_at_perm", ready_a, 1'b0);
        chk("t2_busy_at_perm", busy_a, 1'b1);
        tick();
        perm_done = 1'b0;
        @(negedge clk);
        chk("t2_ready_after_perm_a", ready_a, 1'b1);
        chk("t2_ready_after_perm_b", ready_b, 1'b1);
        tick();
        send_block(1'b1, 1'b0, 0, RL - 1);
        wait_idle();
        chk("t2_block_done_a", n_bd_a, 1);
        chk("t2_block_done_b", n_bd_b, 1);
        chk("t2_all_done_a", n_ad_a, 1);
        chk("t2_xo_count_a", n_xo_a, 34);
        chk("t2_xo_count_b", n_xo_b, 34);
        chk("t2_proto_err", pe_a, 1'b0);

        // Bubbles on msg_valid and a start pulse mid-block.
        clear_counts();
        do_start();
        send_block(1'b0, 1'b1, 0, 3);
        start = 1'b1;
        @(negedge clk);
        chk("t3_ready_during_start", ready_a, 1'b1);
        tick();
        start = 1'b0;
        send_block(1'b1, 1'b1, 4, RL - 1);
        wait_idle();
        chk("t3_xo_count_a", n_xo_a, 17);
        chk("t3_all_done_a", n_ad_a, 1);
        chk("t3_block_done_a", n_bd_a, 0);
        chk("t3_proto_err", pe_a, 1'b0);

        // Protocol errors: early msg_last and perm_done during ABSORB.
        clear_counts();
        do_start();
        for (int i = 0; i <= 5; i++) send_lane(i, i == 5, 1'b0);
        chk("t4_proto_err_rise", pe_a, 1'b1);
        chk("t4_still_absorbing", ready_a, 1'b1);
        perm_done = 1'b1;
        @(negedge clk);
        chk("t4_ready_with_perm", ready_a, 1'b1);
        tick();
        perm_done = 1'b0;
        @(negedge clk);
        chk("t4_ready_after_perm", ready_a, 1'b1);
        tick();
        send_block(1'b1, 1'b0, 6, RL - 1);
        wait_idle();
        chk("t4_proto_err_sticky_a", pe_a, 1'b1);
        chk("t4_proto_err_sticky_b", pe_b, 1'b1);
        chk("t4_all_done_a", n_ad_a, 1);
        chk("t4_block_done_a", n_bd_a, 0);
        chk("t4_xo_count_a", n_xo_a, 17);

        // Asynchronous reset after lane 8.
        clear_counts();
        do_start();
        send_block(1'b0, 1'b0, 0, 8);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ctrl_a", {xv_a, bd_a, ad_a, busy_a, pe_a, ready_a, addr_a, xi_a}, 16'd0);
        chk("t5_rst_xo_data_a", xd_a, 64'd0);
        chk("t5_rst_ctrl_b", {xv_b, busy_b, pe_b, ready_b}, 4'd0);
        q_a.delete();
        q_b.delete();
        repeat (3) tick();
        @(negedge clk);
        chk("t5_xo_in_reset", xv_a, 1'b0);
        tick();
        clear_counts();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("t5_no_xo_after_release", n_xo_a + n_xo_b, 0);
        do_start();
        send_block(1'b1, 1'b0, 0, RL - 1);
        wait_idle();
        chk("t5_xo_count_a", n_xo_a, 17);
        chk("t5_all_done_a", n_ad_a, 1);
        chk("t5_proto_err_cleared", pe_a, 1'b0);
        chk("t5_queue_empty", q_a.size() + q_b.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
